// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: datapath widths, control
// encodings and the bundled ID-stage control word.
package cpu_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned RA_W_DEF   = 5;

   // ALU operation encodings
   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOR  = 4'h5;
   localparam logic [3:0] ALU_SLT  = 4'h6;
   localparam logic [3:0] ALU_SLTU = 4'h7;
   localparam logic [3:0] ALU_SLL  = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_SRA  = 4'hA;

   // Destination register select
   localparam logic [1:0] REGDST_RT = 2'd0;
   localparam logic [1:0] REGDST_RD = 2'd1;
   localparam logic [1:0] REGDST_RA = 2'd2;

   // Write-back source select
   localparam logic [1:0] MEM2REG_ALU = 2'd0;
   localparam logic [1:0] MEM2REG_MEM = 2'd1;
   localparam logic [1:0] MEM2REG_PC4 = 2'd2;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] reg_dst;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] mem_to_reg;
      logic       alu_src1;
      logic       alu_src2;
      logic [3:0] alu_op;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID. $zero never stalls; a flush overrides the stall so the
// PC redirect is never blocked.
module hazard_detect #(
   parameter int unsigned RA_W = 5
) (
   input  logic            reset,
   input  logic            flush,
   input  logic            ex_mem_read,
   input  logic            ex_valid,
   input  logic [RA_W-1:0] ex_rt,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_uses_rt,
   output logic            load_use,
   output logic            stall
);

   // Compare the loaded register against the ID sources
   always_comb begin
      load_use = ex_mem_read & ex_valid & (ex_rt != RA_W'(0)) &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
      stall    = load_use & ~flush & ~reset;
   end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion and flush support.
// Optional feature macro: ID_EX_BUBBLE_CNT_EN adds a 32-bit bubble counter.
module id_ex_reg
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned RA_W   = RA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              id_RegWrite,
   input  logic [1:0]        id_RegDst,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic [1:0]        id_MemtoReg,
   input  logic              id_ALUSrc1,
   input  logic              id_ALUSrc2,
   input  logic [3:0]        id_ALUOp,
   input  logic              id_Branch,
   input  logic              id_uses_rt,
   input  logic [DATA_W-1:0] id_PC_plus_4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_Ext_out,
   input  logic [DATA_W-1:0] id_LU_out,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [RA_W-1:0]   id_shamt,
   output logic              ex_RegWrite,
   output logic [1:0]        ex_RegDst,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic [1:0]        ex_MemtoReg,
   output logic              ex_ALUSrc1,
   output logic              ex_ALUSrc2,
   output logic [3:0]        ex_ALUOp,
   output logic              ex_Branch,
   output logic [DATA_W-1:0] ex_PC_plus_4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_Ext_out,
   output logic [DATA_W-1:0] ex_LU_out,
   output logic [RA_W-1:0]   ex_rs,
   output logic [RA_W-1:0]   ex_rt,
   output logic [RA_W-1:0]   ex_rd,
   output logic [RA_W-1:0]   ex_shamt,
   output logic              ex_valid,
`ifdef ID_EX_BUBBLE_CNT_EN
   output logic [31:0]       bubble_count,
`endif
   output logic              stall
);

   typedef struct packed {
      logic [DATA_W-1:0] pc_plus_4;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] ext_out;
      logic [DATA_W-1:0] lu_out;
      logic [RA_W-1:0]   rs;
      logic [RA_W-1:0]   rt;
      logic [RA_W-1:0]   rd;
      logic [RA_W-1:0]   shamt;
   } data_t;

   ctrl_t ctrl_d, ctrl_q;
   data_t data_d, data_q;
   logic  valid_d, valid_q;
   logic  load_use;
   logic  bubble;

   hazard_detect #(.RA_W(RA_W)) u_hazard (
      .reset       (reset),
      .flush       (flush),
      .ex_mem_read (ctrl_q.mem_read),
      .ex_valid    (valid_q),
      .ex_rt       (data_q.rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .load_use    (load_use),
      .stall       (stall)
   );

   assign bubble = flush | load_use;

   // Next EX contents: bubble zeroes control and validity, data always loads
   always_comb begin
      ctrl_d.reg_write  = id_RegWrite;
      ctrl_d.reg_dst    = id_RegDst;
      ctrl_d.mem_read   = id_MemRead;
      ctrl_d.mem_write  = id_MemWrite;
      ctrl_d.mem_to_reg = id_MemtoReg;
      ctrl_d.alu_src1   = id_ALUSrc1;
      ctrl_d.alu_src2   = id_ALUSrc2;
      ctrl_d.alu_op     = id_ALUOp;
      ctrl_d.branch     = id_Branch;
      valid_d           = 1'b1;
      data_d = '{pc_plus_4: id_PC_plus_4, rs_data: id_rs_data,
                 rt_data: id_rt_data, ext_out: id_Ext_out, lu_out: id_LU_out,
                 rs: id_rs, rt: id_rt, rd: id_rd, shamt: id_shamt};
      if (bubble) begin
         ctrl_d  = CTRL_BUBBLE;
         valid_d = 1'b0;
      end
   end

   // Pipeline register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q  <= CTRL_BUBBLE;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bcnt_q;

   // Count inserted bubbles; wraps naturally
   always_ff @(posedge clk) begin
      if (reset)       bcnt_q <= '0;
      else if (bubble) bcnt_q <= bcnt_q + 32'd1;
   end

   assign bubble_count = bcnt_q;
`endif

   assign ex_RegWrite  = ctrl_q.reg_write;
   assign ex_RegDst    = ctrl_q.reg_dst;
   assign ex_MemRead   = ctrl_q.mem_read;
   assign ex_MemWrite  = ctrl_q.mem_write;
   assign ex_MemtoReg  = ctrl_q.mem_to_reg;
   assign ex_ALUSrc1   = ctrl_q.alu_src1;
   assign ex_ALUSrc2   = ctrl_q.alu_src2;
   assign ex_ALUOp     = ctrl_q.alu_op;
   assign ex_Branch    = ctrl_q.branch;
   assign ex_PC_plus_4 = data_q.pc_plus_4;
   assign ex_rs_data   = data_q.rs_data;
   assign ex_rt_data   = data_q.rt_data;
   assign ex_Ext_out   = data_q.ext_out;
   assign ex_LU_out    = data_q.lu_out;
   assign ex_rs        = data_q.rs;
   assign ex_rt        = data_q.rt;
   assign ex_rd        = data_q.rd;
   assign ex_shamt     = data_q.shamt;
   assign ex_valid     = valid_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized + directed bench for id_ex_reg against a transaction-level model.
// Honours ID_EX_BUBBLE_CNT_EN when defined.
module tb_id_ex_reg;

   logic        clk, reset, flush;
   logic        id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc1, id_ALUSrc2;
   logic        id_Branch, id_uses_rt;
   logic [1:0]  id_RegDst, id_MemtoReg;
   logic [3:0]  id_ALUOp;
   logic [31:0] id_PC_plus_4, id_rs_data, id_rt_data, id_Ext_out, id_LU_out;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc1, ex_ALUSrc2;
   logic        ex_Branch, ex_valid, stall;
   logic [1:0]  ex_RegDst, ex_MemtoReg;
   logic [3:0]  ex_ALUOp;
   logic [31:0] ex_PC_plus_4, ex_rs_data, ex_rt_data, ex_Ext_out, ex_LU_out;
   logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_count;
`endif

   id_ex_reg dut (
      .clk(clk), .reset(reset), .flush(flush),
      .id_RegWrite(id_RegWrite), .id_RegDst(id_RegDst), .id_MemRead(id_MemRead),
      .id_MemWrite(id_MemWrite), .id_MemtoReg(id_MemtoReg), .id_ALUSrc1(id_ALUSrc1),
      .id_ALUSrc2(id_ALUSrc2), .id_ALUOp(id_ALUOp), .id_Branch(id_Branch),
      .id_uses_rt(id_uses_rt), .id_PC_plus_4(id_PC_plus_4), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_Ext_out(id_Ext_out), .id_LU_out(id_LU_out),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .ex_RegWrite(ex_RegWrite), .ex_RegDst(ex_RegDst), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc1(ex_ALUSrc1),
      .ex_ALUSrc2(ex_ALUSrc2), .ex_ALUOp(ex_ALUOp), .ex_Branch(ex_Branch),
      .ex_PC_plus_4(ex_PC_plus_4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
      .ex_Ext_out(ex_Ext_out), .ex_LU_out(ex_LU_out), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_shamt(ex_shamt), .ex_valid(ex_valid),
`ifdef ID_EX_BUBBLE_CNT_EN
      .bubble_count(bubble_count),
`endif
      .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference state: what EX should hold
   logic [13:0]  m_ctrl;
   logic [179:0] m_data;
   logic         m_known, m_valid, m_memread;
   logic [4:0]   m_rt;
   logic [31:0]  m_bcnt;

   task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [13:0] id_ctrl();
      return {id_RegWrite, id_RegDst, id_MemRead, id_MemWrite, id_MemtoReg,
              id_ALUSrc1, id_ALUSrc2, id_ALUOp, id_Branch};
   endfunction

   function automatic logic [13:0] ex_ctrl();
      return {ex_RegWrite, ex_RegDst, ex_MemRead, ex_MemWrite, ex_MemtoReg,
              ex_ALUSrc1, ex_ALUSrc2, ex_ALUOp, ex_Branch};
   endfunction

   function automatic logic [179:0] id_data();
      return {id_PC_plus_4, id_rs_data, id_rt_data, id_Ext_out, id_LU_out,
              id_rs, id_rt, id_rd, id_shamt};
   endfunction

   function automatic logic [179:0] ex_data();
      return {ex_PC_plus_4, ex_rs_data, ex_rt_data, ex_Ext_out, ex_LU_out,
              ex_rs, ex_rt, ex_rd, ex_shamt};
   endfunction

   task automatic check_ex();
      check_val("ex_valid", 192'(ex_valid), 192'(m_valid));
      check_val("ex_ctrl", 192'(ex_ctrl()), 192'(m_ctrl));
      if (m_known) check_val("ex_data", 192'(ex_data()), 192'(m_data));
`ifdef ID_EX_BUBBLE_CNT_EN
      check_val("bubble_count", 192'(bubble_count), 192'(m_bcnt));
`endif
   endtask

   // One clock with inputs already applied; returns the observed stall
   task automatic do_cycle(output logic s);
      logic lu;
      #1;
      check_val("ex_hold", 192'({ex_valid, ex_ctrl()}), 192'({m_valid, m_ctrl}));
      lu = m_valid && m_memread && (m_rt != 5'd0) &&
           ((m_rt == id_rs) || (id_uses_rt && (m_rt == id_rt)));
      s = stall;
      check_val("stall", 192'(stall), 192'(lu && !flush && !reset));
      if (reset) begin
         m_ctrl = '0; m_data = '0; m_known = 1'b1; m_valid = 1'b0;
         m_memread = 1'b0; m_rt = '0; m_bcnt = '0;
      end else if (flush || lu) begin
         m_ctrl = '0; m_known = 1'b0; m_valid = 1'b0; m_memread = 1'b0;
         m_bcnt = m_bcnt + 32'd1;
      end else begin
         m_ctrl = id_ctrl(); m_data = id_data(); m_known = 1'b1; m_valid = 1'b1;
         m_memread = id_MemRead; m_rt = id_rt;
      end
      @(posedge clk);
      #1;
      check_ex();
   endtask

   task automatic rand_id();
      id_RegWrite  = 1'($urandom); id_RegDst   = 2'($urandom);
      id_MemRead   = ($urandom_range(0, 2) == 0);
      id_MemWrite  = 1'($urandom); id_MemtoReg = 2'($urandom);
      id_ALUSrc1   = 1'($urandom); id_ALUSrc2  = 1'($urandom);
      id_ALUOp     = 4'($urandom); id_Branch   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_PC_plus_4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom;
      id_Ext_out   = $urandom; id_LU_out  = $urandom;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom); id_shamt = 5'($urandom);
   endtask

   // Directed instruction: random payload with chosen hazard-relevant fields
   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                         input logic mrd, input logic urt, input logic fl);
      rand_id();
      id_rs = rs; id_rt = rt; id_MemRead = mrd; id_uses_rt = urt;
      id_RegWrite = 1'b1; flush = fl; reset = 1'b0;
   endtask

   logic s;

   initial begin
      m_ctrl = '0; m_data = '0; m_known = 1'b0; m_valid = 1'b0;
      m_memread = 1'b0; m_rt = '0; m_bcnt = '0;
      reset = 1'b1; flush = 1'b0;
      rand_id();
      id_RegWrite = 1'b1; id_ALUOp = 4'hF; id_rs_data = 32'hDEADBEEF;
      @(negedge clk);
      // Reset held two cycles with nonzero inputs
      do_cycle(s);
      do_cycle(s);
      check_val("reset_valid", 192'(ex_valid), 192'(1'b0));
      check_val("reset_rs_data", 192'(ex_rs_data), 192'(32'h0));
      reset = 1'b0;
      id_MemRead = 1'b0;
      do_cycle(s);
      check_val("release_valid", 192'(ex_valid), 192'(1'b1));

      // Plain pass-through
      set_id(5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
      id_ALUOp = 4'h2; id_rs_data = 32'h12345678; id_rd = 5'd8;
      do_cycle(s);
      check_val("pass_stall", 192'(s), 192'(1'b0));
      check_val("pass_aluop", 192'(ex_ALUOp), 192'(4'h2));
      check_val("pass_rs_data", 192'(ex_rs_data), 192'(32'h12345678));
      check_val("pass_rd", 192'(ex_rd), 192'(5'd8));

      // Load-use on rs
      set_id(5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
      do_cycle(s);
      set_id(5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
      do_cycle(s);
      check_val("lu_rs_stall", 192'(s), 192'(1'b1));
      check_val("lu_rs_regwrite", 192'(ex_RegWrite), 192'(1'b0));
      check_val("lu_rs_bubble", 192'(ex_valid), 192'(1'b0));
      do_cycle(s);
      check_val("lu_rs_stall2", 192'(s), 192'(1'b0));
      check_val("lu_rs_dep_in_ex", 192'({ex_valid, ex_rs}), 192'({1'b1, 5'd8}));

      // rt dependency gated by uses_rt
      set_id(5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
      do_cycle(s);
      set_id(5'd2, 5'd9, 1'b0, 1'b0, 1'b0);
      do_cycle(s);
      check_val("rt_unused_stall", 192'(s), 192'(1'b0));
      set_id(5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
      do_cycle(s);
      set_id(5'd2, 5'd9, 1'b0, 1'b1, 1'b0);
      do_cycle(s);
      check_val("rt_used_stall", 192'(s), 192'(1'b1));
      do_cycle(s);
      // $zero never stalls
      set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
      do_cycle(s);
      set_id(5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      do_cycle(s);
      check_val("zero_stall", 192'(s), 192'(1'b0));

      // Flush beats load-use
      set_id(5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
      do_cycle(s);
      set_id(5'd8, 5'd8, 1'b0, 1'b1, 1'b1);
      id_MemWrite = 1'b1; id_Branch = 1'b1;
      do_cycle(s);
      check_val("flush_stall", 192'(s), 192'(1'b0));
      check_val("flush_bubble", 192'({ex_MemWrite, ex_Branch, ex_valid}), 192'(3'b000));

      // Reset mid-stall
      set_id(5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
      do_cycle(s);
      set_id(5'd8, 5'd1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      do_cycle(s);
      check_val("rst_stall", 192'(s), 192'(1'b0));
      reset = 1'b0;
      do_cycle(s);
      check_val("rst_after_stall", 192'(s), 192'(1'b0));

      // Bubble count: 3 flushes + 2 load-use events after reset
      reset = 1'b1;
      do_cycle(s);
      for (int i = 0; i < 3; i++) begin
         set_id(5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
         do_cycle(s);
      end
      for (int i = 0; i < 2; i++) begin
         set_id(5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
         do_cycle(s);
         set_id(5'd8, 5'd2, 1'b0, 1'b0, 1'b0);
         do_cycle(s);
         do_cycle(s);
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      check_val("bcnt_five", 192'(bubble_count), 192'(32'd5));
      reset = 1'b1;
      do_cycle(s);
      check_val("bcnt_reset", 192'(bubble_count), 192'(32'd0));
`endif

      // Randomized traffic; a stalled instruction is re-presented
      reset = 1'b0; flush = 1'b0;
      s = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!s) rand_id();
         flush = ($urandom_range(0, 7) == 0);
         reset = ($urandom_range(0, 63) == 0);
         do_cycle(s);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
